board_state_mem: RTL and testbench
==================================

Name: board_state_mem

Overview:
- Parametrised minesweeper board store. It replaces the fixed 256-entry, mine-only map.
- Per cell it holds: mine, revealed and flagged bits, plus a 4-bit neighbour-mine count that the block computes itself.
- It executes reveal and flag commands from the cursor/select logic and reports game-over (mine hit) and win conditions.
- Sits between mines_placer (write port), the cursor/selection logic (command port) and the VGA draw path (pixel read port).

Parameters:
- GRID_W, 16, board columns (2..64).
- GRID_H, 16, board rows (2..64).
- CELLS, GRID_W*GRID_H, derived localparam.
- ADDR_W, $clog2(CELLS), derived localparam; address = y*GRID_W + x.
- CNT_W, $clog2(CELLS+1), derived localparam; width of the mine and revealed counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- clear  in  1  one-cycle pulse; wipe the board
- mine_wr_en  in  1  mine write strobe from the placer
- mine_wr_addr  in  ADDR_W  cell to write
- mine_wr_data  in  1  mine bit
- count_start  in  1  pulse; compute neighbour counts
- count_done  out  1  one-cycle pulse when the count pass finishes
- num_mines  in  CNT_W  mines placed; sampled at count_start
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when the block is IDLE
- cmd_op  in  2  00 = reveal, 01 = flag toggle, 1x = ignored
- cmd_addr  in  ADDR_W  target cell
- rd_addr  in  ADDR_W  pixel-path cell address
- rd_cell  out  7  {mine, revealed, flagged, count[3:0]}; registered
- busy  out  1  high when not IDLE
- mine_hit  out  1  sticky: a mine was revealed
- board_won  out  1  sticky: all safe cells are revealed
- revealed_cnt  out  CNT_W  number of cells revealed

Behaviour:
- Reset (rst low):
  - All cell bits = 0.
  - State = IDLE; count_done = 0, mine_hit = 0, board_won = 0, revealed_cnt = 0, rd_cell = 0.
- Storage:
  - Mine bits live in a flop array so all 8 neighbours can be read in parallel.
  - revealed, flagged and count live in flop arrays.
- rd_cell: 1-cycle latency; rd_cell at cycle n+1 reflects rd_addr and array contents at cycle n. It is valid in every state.
- FSM states: IDLE, CLEAR, COUNT, EXEC.
  - IDLE → CLEAR on clear.
    - CLEAR takes CELLS cycles, zeroing one cell per cycle by index.
    - mine_hit, board_won and revealed_cnt are zeroed on entry.
    - Returns to IDLE afterwards.
  - IDLE → COUNT on count_start (when clear is low).
    - Index walks 0..CELLS-1, one cell per cycle: count[i] = number of mine neighbours.
    - Neighbours outside the grid count as 0; there is no wrap-around. The cell's own mine bit is excluded.
    - On the last cell, count_done pulses for 1 cycle and the FSM returns to IDLE.
    - Total latency: CELLS+1 cycles from count_start to count_done.
  - IDLE → EXEC when cmd_valid && cmd_ready. EXEC lasts 1 cycle, then returns to IDLE.
    - Reveal ignored if the target is flagged or already revealed.
    - Reveal of a mine: set revealed, set mine_hit.
    - Reveal of a safe cell: set revealed, revealed_cnt += 1.
    - Flag toggle ignored if the target is revealed.
    - Once mine_hit or board_won is set, all further commands are accepted but have no effect.
- board_won is set on the cycle after revealed_cnt reaches CELLS - num_mines_latched while mine_hit = 0.
- Priority in IDLE when events coincide: clear > count_start > cmd_valid.
- Non-IDLE input handling:
  - mine_wr_en honoured only in IDLE; silently dropped otherwise.
  - clear, count_start and cmd_valid are ignored outside IDLE; cmd_ready = 0 there.
- Async reset mid-CLEAR or mid-COUNT aborts the pass; the board returns to the reset state.

Optional Feature:
- SHOW_MINES_EN defined:
  - Adds input port show_mines (1 bit).
  - While it is high, the rd_cell revealed bit = revealed | mine. This is a debug view only; stored state and counters are unchanged.
- Undefined: the port is absent and the revealed bit comes straight from the array.

Decomposition:
- Package board_pkg holds:
  - cmd_op encodings OP_REVEAL and OP_FLAG;
  - the FSM state enum;
  - rd_cell field offsets (CELL_MINE = 6, CELL_REV = 5, CELL_FLAG = 4, CELL_CNT lsb = 0).
- Sub-module nbr_count: combinational.
  - Inputs: the 8 neighbour mine bits and the x/y position of the cell.
  - It masks out-of-grid neighbours and outputs the 4-bit count.
  - It is instantiated once, driven by the COUNT index.

Test Plan:
- Reset, then clear, then wait 256 cycles → busy falls 256 cycles after clear; rd_cell = 0 at every address; revealed_cnt = 0.
- Mines at addr 0 and 17, num_mines = 2, count_start → count_done exactly 257 cycles later; count[1] = 2, count[16] = 2, count[18] = 1, count[255] = 0; corner cell 0 sees no wrapped neighbour from 15 or 240.
- Flag addr 5, then reveal addr 5 → rd_cell revealed stays 0, revealed_cnt = 0; flag again, then reveal → revealed = 1, revealed_cnt = 1.
- Reveal addr 17 (a mine) → mine_hit = 1 next cycle; a subsequent reveal of addr 3 leaves revealed_cnt unchanged.
- GRID_W = 4, GRID_H = 4, 1 mine at addr 15; reveal the other 15 cells → board_won = 1 after the 15th reveal; mine_hit = 0.
- count_start and cmd_valid asserted in the same IDLE cycle → COUNT runs, cmd_ready = 0, command dropped; mine_wr_en during COUNT → mine bit unchanged.

Source files
------------

// File: rtl/board_state_mem_pkg.sv
// rtl/board_state_mem_pkg.sv - shared encodings for the minesweeper board store
//
// Package board_pkg:
//   OP_REVEAL / OP_FLAG      command opcodes on cmd_op
//   state_t                  FSM states of board_state_mem
//   CELL_MINE/REV/FLAG/CNT   bit offsets inside rd_cell
package board_pkg;

  localparam logic [1:0] OP_REVEAL = 2'b00;
  localparam logic [1:0] OP_FLAG   = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COUNT,
    EXEC
  } state_t;

  localparam int CELL_MINE = 6;
  localparam int CELL_REV  = 5;
  localparam int CELL_FLAG = 4;
  localparam int CELL_CNT  = 0;

endpackage

// File: rtl/board_state_mem_if.sv
// rtl/board_state_mem_if.sv - board store bus: placer, command, pixel and status signals
//
// Parameters: ADDR_W (cell address width), CNT_W (mine/revealed counter width)
// Groups: clear / count_start / count_done / num_mines        board control
//         mine_wr_en / mine_wr_addr / mine_wr_data              placer write port
//         cmd_valid / cmd_ready / cmd_op / cmd_addr             command port
//         rd_addr / rd_cell                                     pixel read port
//         busy / mine_hit / board_won / revealed_cnt            status
//         show_mines (only with SHOW_MINES_EN defined)          debug view
// Modports: master drives requests, slave is the board store.
interface board_state_mem_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
);
  logic              clear;
  logic              mine_wr_en;
  logic [ADDR_W-1:0] mine_wr_addr;
  logic              mine_wr_data;
  logic              count_start;
  logic              count_done;
  logic [CNT_W-1:0]  num_mines;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [6:0]        rd_cell;
  logic              busy;
  logic              mine_hit;
  logic              board_won;
  logic [CNT_W-1:0]  revealed_cnt;
`ifdef SHOW_MINES_EN
  logic              show_mines;
`endif

  modport master (
    output clear, mine_wr_en, mine_wr_addr, mine_wr_data, count_start, num_mines,
           cmd_valid, cmd_op, cmd_addr, rd_addr,
`ifdef SHOW_MINES_EN
           show_mines,
`endif
    input  count_done, cmd_ready, rd_cell, busy, mine_hit, board_won, revealed_cnt
  );

  modport slave (
    input  clear, mine_wr_en, mine_wr_addr, mine_wr_data, count_start, num_mines,
           cmd_valid, cmd_op, cmd_addr, rd_addr,
`ifdef SHOW_MINES_EN
           show_mines,
`endif
    output count_done, cmd_ready, rd_cell, busy, mine_hit, board_won, revealed_cnt
  );

endinterface

// File: rtl/board_state_mem_nbr_count.sv
// rtl/board_state_mem_nbr_count.sv - neighbour mine counter for one cell (combinational)
//
// Ports: nbr   in  8   neighbour mine bits {SE,S,SW,E,W,NE,N,NW} (bit 0 = NW)
//        x     in  XW  cell column
//        y     in  YW  cell row
//        count out 4   mines among the in-grid neighbours
module nbr_count #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic [7:0]    nbr,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [3:0]    count
);

  logic       has_l, has_r, has_t, has_b;
  logic [7:0] mask;

  always_comb begin
    has_l = (x != '0);
    has_r = (x != XW'(GRID_W - 1));
    has_t = (y != '0);
    has_b = (y != YW'(GRID_H - 1));
    // Linear addressing wraps rows into each other; edge masks stop that.
    mask  = {has_b & has_r, has_b, has_b & has_l, has_r, has_l,
             has_t & has_r, has_t, has_t & has_l};
    count = 4'($countones(nbr & mask));
  end

endmodule

// File: rtl/board_state_mem.sv
// rtl/board_state_mem.sv - parametrised minesweeper board store with reveal/flag engine
//
// Parameters: GRID_W, GRID_H (2..64); address = y*GRID_W + x
// Ports: clk  in  system clock
//        rst  in  asynchronous active-low reset
//        bus  board_state_mem_if.slave (placer write, command, pixel read, status)
// Optional macro SHOW_MINES_EN: adds bus.show_mines, which ORs the mine bit into
// the revealed bit of rd_cell for a debug view.
module board_state_mem
  import board_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16
) (
  input  logic              clk,
  input  logic              rst,
  board_state_mem_if.slave  bus
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int XW     = $clog2(GRID_W);
  localparam int YW     = $clog2(GRID_H);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  state_t                  state;
  logic [ADDR_W-1:0]       idx, addr_q;
  logic [XW-1:0]           cx;
  logic [YW-1:0]           cy;
  logic [1:0]              op_q;
  logic [CNT_W-1:0]        nm_lat, rev_cnt;
  logic                    done_q, hit_q, won_q;
  logic [CELLS-1:0]        mine, rev, flag;
  logic [CELLS-1:0][3:0]   cnt;
  logic [7:0]              nbr;
  logic [3:0]              nbr_cnt;
  logic [6:0]              rd_d, rd_q;
  logic                    wr_ok, cmd_ok, rd_ok, all_safe;

  function automatic logic mine_at(input logic [CELLS-1:0] m, input int a);
    if (a < 0 || a >= CELLS) return 1'b0;
    return m[ADDR_W'(a)];
  endfunction

  // Neighbours of the COUNT index; wrapped ones are masked in nbr_count.
  always_comb begin
    int base;
    base   = int'(idx);
    nbr[0] = mine_at(mine, base - GRID_W - 1);
    nbr[1] = mine_at(mine, base - GRID_W);
    nbr[2] = mine_at(mine, base - GRID_W + 1);
    nbr[3] = mine_at(mine, base - 1);
    nbr[4] = mine_at(mine, base + 1);
    nbr[5] = mine_at(mine, base + GRID_W - 1);
    nbr[6] = mine_at(mine, base + GRID_W);
    nbr[7] = mine_at(mine, base + GRID_W + 1);
  end

  nbr_count #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_nbr_count (
    .nbr   (nbr),
    .x     (cx),
    .y     (cy),
    .count (nbr_cnt)
  );

  assign wr_ok    = int'(bus.mine_wr_addr) < CELLS;
  assign cmd_ok   = int'(addr_q) < CELLS;
  assign rd_ok    = int'(bus.rd_addr) < CELLS;
  assign all_safe = (rev_cnt == CNT_W'(CELLS) - nm_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      cx      <= '0;
      cy      <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      nm_lat  <= '0;
      rev_cnt <= '0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      won_q   <= 1'b0;
      mine    <= '0;
      rev     <= '0;
      flag    <= '0;
      cnt     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mine_wr_en && wr_ok) mine[bus.mine_wr_addr] <= bus.mine_wr_data;
          if (!hit_q && all_safe) won_q <= 1'b1;
          if (bus.clear) begin
            state   <= CLEAR;
            idx     <= '0;
            hit_q   <= 1'b0;
            won_q   <= 1'b0;
            rev_cnt <= '0;
          end else if (bus.count_start) begin
            state  <= COUNT;
            idx    <= '0;
            cx     <= '0;
            cy     <= '0;
            nm_lat <= bus.num_mines;
          end else if (bus.cmd_valid) begin
            state  <= EXEC;
            op_q   <= bus.cmd_op;
            addr_q <= bus.cmd_addr;
          end
        end
        CLEAR: begin
          mine[idx] <= 1'b0;
          rev[idx]  <= 1'b0;
          flag[idx] <= 1'b0;
          cnt[idx]  <= '0;
          idx       <= idx + ADDR_W'(1);
          if (idx == LAST) state <= IDLE;
        end
        COUNT: begin
          cnt[idx] <= nbr_cnt;
          idx      <= idx + ADDR_W'(1);
          if (cx == XW'(GRID_W - 1)) begin
            cx <= '0;
            cy <= cy + YW'(1);
          end else begin
            cx <= cx + XW'(1);
          end
          if (idx == LAST) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        EXEC: begin
          // A finished game freezes the board; commands are still consumed.
          if (!hit_q && !won_q && cmd_ok) begin
            case (op_q)
              OP_REVEAL: begin
                if (!flag[addr_q] && !rev[addr_q]) begin
                  rev[addr_q] <= 1'b1;
                  if (mine[addr_q]) hit_q   <= 1'b1;
                  else              rev_cnt <= rev_cnt + CNT_W'(1);
                end
              end
              OP_FLAG: begin
                if (!rev[addr_q]) flag[addr_q] <= ~flag[addr_q];
              end
              default: ;
            endcase
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    if (rd_ok) begin
      rd_d[CELL_MINE]      = mine[bus.rd_addr];
`ifdef SHOW_MINES_EN
      rd_d[CELL_REV]       = rev[bus.rd_addr] | (bus.show_mines & mine[bus.rd_addr]);
`else
      rd_d[CELL_REV]       = rev[bus.rd_addr];
`endif
      rd_d[CELL_FLAG]      = flag[bus.rd_addr];
      rd_d[CELL_CNT +: 4]  = cnt[bus.rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= rd_d;
  end

  assign bus.rd_cell      = rd_q;
  assign bus.cmd_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.count_done   = done_q;
  assign bus.mine_hit     = hit_q;
  assign bus.board_won    = won_q;
  assign bus.revealed_cnt = rev_cnt;

endmodule

// File: tb/tb_board_state_mem.sv
// tb/tb_board_state_mem.sv - scoreboard bench for board_state_mem (16x16 and 4x4 instances)
module tb_board_state_mem;
  import board_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  board_state_mem_if #(.ADDR_W(8), .CNT_W(9)) a ();
  board_state_mem_if #(.ADDR_W(4), .CNT_W(5)) b ();

  board_state_mem #(.GRID_W(16), .GRID_H(16)) d16 (.clk(clk), .rst(rst), .bus(a));
  board_state_mem #(.GRID_W(4),  .GRID_H(4))  d4  (.clk(clk), .rst(rst), .bus(b));

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];
  bit m16[256];
  bit r16[256];
  bit f16[256];
  int c16[256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_cnt(int i);
    int x, y, n;
    x = i % 16;
    y = i / 16;
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 16 && y + dy >= 0 && y + dy < 16)
          n += int'(m16[(y + dy) * 16 + x + dx]);
    return n;
  endfunction

  function automatic logic [6:0] model_cell(int i);
    return {m16[i], r16[i], f16[i], 4'(c16[i])};
  endfunction

  task automatic rd16(input int addr, output logic [6:0] obs);
    a.rd_addr = 8'(addr);
    tick();
    obs = a.rd_cell;
  endtask

  task automatic send16(input logic [1:0] op, input int addr);
    a.cmd_valid = 1'b1;
    a.cmd_op    = op;
    a.cmd_addr  = 8'(addr);
    tick();
    a.cmd_valid = 1'b0;
    tick();
  endtask

  task automatic send4(input logic [1:0] op, input int addr);
    b.cmd_valid = 1'b1;
    b.cmd_op    = op;
    b.cmd_addr  = 4'(addr);
    tick();
    b.cmd_valid = 1'b0;
    tick();
  endtask

  task automatic write16(input int addr, input bit val);
    a.mine_wr_en   = 1'b1;
    a.mine_wr_addr = 8'(addr);
    a.mine_wr_data = val;
    tick();
    a.mine_wr_en   = 1'b0;
    m16[addr]      = val;
  endtask

  task automatic test_reset();
    a.rd_addr = '0;
    #2;
    if (a.busy !== 1'b0 || a.cmd_ready !== 1'b1) begin
      $display("FAIL reset_state: busy=%b cmd_ready=%b want 0/1", a.busy, a.cmd_ready);
      miscompares++;
    end
    vectors++;
    if ({a.mine_hit, a.board_won, a.count_done} !== 3'b000 || a.revealed_cnt !== 9'd0) begin
      $display("FAIL reset_status: hit/won/done=%b%b%b cnt=%0d want 000/0",
               a.mine_hit, a.board_won, a.count_done, a.revealed_cnt);
      miscompares++;
    end
    vectors++;
    if (a.rd_cell !== 7'd0 || b.busy !== 1'b0) begin
      $display("FAIL reset_rd_cell: rd_cell=%b b.busy=%b want 0/0", a.rd_cell, b.busy);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_clear();
    logic [6:0] obs, exp;
    int cyc;
    write16(3, 1'b1);
    write16(200, 1'b1);
    exp_q.push_back(model_cell(3));
    rd16(3, obs);
    exp = exp_q.pop_front();
    if (obs !== exp) begin
      $display("FAIL pre_clear_cell3: got %b want %b", obs, exp);
      miscompares++;
    end
    vectors++;
    a.clear = 1'b1;
    tick();
    a.clear = 1'b0;
    cyc = 0;
    while (a.busy && cyc < 1000) begin
      tick();
      cyc++;
    end
    if (cyc !== 256) begin
      $display("FAIL clear_busy_cycles: got %0d want 256", cyc);
      miscompares++;
    end
    vectors++;
    for (int i = 0; i < 256; i++) begin
      m16[i] = 0; r16[i] = 0; f16[i] = 0; c16[i] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(model_cell(i));
      rd16(i, obs);
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        $display("FAIL clear_sweep cell %0d: got %b want %b", i, obs, exp);
        miscompares++;
      end
      vectors++;
    end
    if (a.revealed_cnt !== 9'd0) begin
      $display("FAIL clear_revealed_cnt: got %0d want 0", a.revealed_cnt);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_count();
    logic [6:0] obs, exp;
    int lat;
    write16(0, 1'b1);
    write16(17, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        write16(15, 1'b1);
        write16(240, 1'b1);
      end
      a.num_mines   = (pass == 0) ? 9'd2 : 9'd4;
      a.count_start = 1'b1;
      tick();
      a.count_start = 1'b0;
      lat = 1;
      while (!a.count_done && lat < 1000) begin
        tick();
        lat++;
      end
      if (lat !== 257) begin
        $display("FAIL count_latency pass %0d: got %0d want 257", pass, lat);
        miscompares++;
      end
      vectors++;
      tick();
      if (a.count_done !== 1'b0) begin
        $display("FAIL count_done_pulse: got %b want 0", a.count_done);
        miscompares++;
      end
      vectors++;
      for (int i = 0; i < 256; i++) c16[i] = model_cnt(i);
      if (pass == 0) begin
        // Known values for mines at 0 and 17.
        exp_q.push_back(7'b0000010); exp_q.push_back(7'b0000010);
        exp_q.push_back(7'b0000001); exp_q.push_back(7'b0000000);
        exp_q.push_back(7'b1000001);
        foreach (exp_q[k]) begin
          int addr;
          case (k)
            0: addr = 1;
            1: addr = 16;
            2: addr = 18;
            3: addr = 255;
            default: addr = 0;
          endcase
          rd16(addr, obs);
          if (obs !== exp_q[k]) begin
            $display("FAIL count_fixed cell %0d: got %b want %b", addr, obs, exp_q[k]);
            miscompares++;
          end
          vectors++;
        end
        exp_q.delete();
      end
      for (int i = 0; i < 256; i++) begin
        exp_q.push_back(model_cell(i));
        rd16(i, obs);
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          $display("FAIL count_sweep pass %0d cell %0d: got %b want %b", pass, i, obs, exp);
          miscompares++;
        end
        vectors++;
      end
    end
  endtask

  task automatic test_flag();
    logic [6:0] obs, exp;
    for (int step = 0; step < 5; step++) begin
      case (step)
        0: begin send16(OP_FLAG, 5);   f16[5] = 1; end
        1: begin send16(OP_REVEAL, 5); end
        2: begin send16(OP_FLAG, 5);   f16[5] = 0; end
        3: begin send16(OP_REVEAL, 5); r16[5] = 1; end
        default: begin send16(OP_FLAG, 5); end
      endcase
      exp_q.push_back(model_cell(5));
      rd16(5, obs);
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        $display("FAIL flag_step%0d cell5: got %b want %b", step, obs, exp);
        miscompares++;
      end
      vectors++;
      if (a.revealed_cnt !== ((step >= 3) ? 9'd1 : 9'd0)) begin
        $display("FAIL flag_step%0d revealed_cnt: got %0d want %0d", step, a.revealed_cnt,
                 (step >= 3) ? 1 : 0);
        miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs, exp;
    int lat;
    a.count_start = 1'b1;
    a.cmd_valid   = 1'b1;
    a.cmd_op      = OP_REVEAL;
    a.cmd_addr    = 8'd3;
    tick();
    a.count_start = 1'b0;
    a.cmd_valid   = 1'b0;
    if (a.cmd_ready !== 1'b0 || a.busy !== 1'b1) begin
      $display("FAIL b2b_count_busy: cmd_ready=%b busy=%b want 0/1", a.cmd_ready, a.busy);
      miscompares++;
    end
    vectors++;
    a.mine_wr_en   = 1'b1;
    a.mine_wr_addr = 8'd2;
    a.mine_wr_data = 1'b1;
    tick();
    a.mine_wr_en   = 1'b0;
    lat = 2;
    while (!a.count_done && lat < 1000) begin
      tick();
      lat++;
    end
    if (lat !== 257) begin
      $display("FAIL b2b_count_latency: got %0d want 257", lat);
      miscompares++;
    end
    vectors++;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(model_cell(i));
      rd16(i, obs);
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        $display("FAIL b2b_sweep cell %0d: got %b want %b", i, obs, exp);
        miscompares++;
      end
      vectors++;
    end
    if (a.revealed_cnt !== 9'd1) begin
      $display("FAIL b2b_revealed_cnt: got %0d want 1", a.revealed_cnt);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_mine_hit();
    logic [6:0] obs, exp;
    send16(OP_REVEAL, 17);
    r16[17] = 1;
    if (a.mine_hit !== 1'b1) begin
      $display("FAIL mine_hit_set: got %b want 1", a.mine_hit);
      miscompares++;
    end
    vectors++;
    send16(OP_REVEAL, 3);
    send16(OP_FLAG, 4);
    if (a.revealed_cnt !== 9'd1 || a.board_won !== 1'b0) begin
      $display("FAIL after_hit_status: cnt=%0d won=%b want 1/0", a.revealed_cnt, a.board_won);
      miscompares++;
    end
    vectors++;
    for (int i = 3; i < 18; i++) begin
      exp_q.push_back(model_cell(i));
      rd16(i, obs);
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        $display("FAIL after_hit cell %0d: got %b want %b", i, obs, exp);
        miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_win();
    int lat;
    b.mine_wr_en   = 1'b1;
    b.mine_wr_addr = 4'd15;
    b.mine_wr_data = 1'b1;
    tick();
    b.mine_wr_en   = 1'b0;
    b.num_mines    = 5'd1;
    b.count_start  = 1'b1;
    tick();
    b.count_start  = 1'b0;
    lat = 1;
    while (!b.count_done && lat < 100) begin
      tick();
      lat++;
    end
    if (lat !== 17) begin
      $display("FAIL win_count_latency: got %0d want 17", lat);
      miscompares++;
    end
    vectors++;
    for (int i = 0; i < 15; i++) begin
      send4(OP_REVEAL, i);
      if (i == 13) begin
        tick();
        if (b.board_won !== 1'b0 || b.revealed_cnt !== 5'd14) begin
          $display("FAIL win_early: won=%b cnt=%0d want 0/14", b.board_won, b.revealed_cnt);
          miscompares++;
        end
        vectors++;
      end
    end
    tick();
    if (b.board_won !== 1'b1 || b.mine_hit !== 1'b0 || b.revealed_cnt !== 5'd15) begin
      $display("FAIL win_set: won=%b hit=%b cnt=%0d want 1/0/15",
               b.board_won, b.mine_hit, b.revealed_cnt);
      miscompares++;
    end
    vectors++;
    send4(OP_REVEAL, 15);
    if (b.mine_hit !== 1'b0 || b.board_won !== 1'b1) begin
      $display("FAIL win_frozen: hit=%b won=%b want 0/1", b.mine_hit, b.board_won);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_abort();
    logic [6:0] obs;
    b.count_start = 1'b1;
    tick();
    b.count_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    if (b.busy !== 1'b0 || a.mine_hit !== 1'b0 || b.board_won !== 1'b0 || b.revealed_cnt !== 5'd0) begin
      $display("FAIL async_reset: b.busy=%b a.hit=%b b.won=%b b.cnt=%0d want 0/0/0/0",
               b.busy, a.mine_hit, b.board_won, b.revealed_cnt);
      miscompares++;
    end
    vectors++;
    tick();
    rst = 1'b1;
    exp_q.push_back(7'd0);
    rd16(17, obs);
    if (obs !== exp_q.pop_front()) begin
      $display("FAIL reset_cell17: got %b want 0", obs);
      miscompares++;
    end
    vectors++;
  endtask

  initial begin
    a.clear = 0; a.mine_wr_en = 0; a.mine_wr_addr = '0; a.mine_wr_data = 0;
    a.count_start = 0; a.num_mines = '0; a.cmd_valid = 0; a.cmd_op = '0;
    a.cmd_addr = '0; a.rd_addr = '0;
    b.clear = 0; b.mine_wr_en = 0; b.mine_wr_addr = '0; b.mine_wr_data = 0;
    b.count_start = 0; b.num_mines = '0; b.cmd_valid = 0; b.cmd_op = '0;
    b.cmd_addr = '0; b.rd_addr = '0;
`ifdef SHOW_MINES_EN
    a.show_mines = 0;
    b.show_mines = 0;
`endif
    repeat (2) tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_clear();
    test_count();
    test_flag();
    test_back_to_back();
    test_mine_hit();
    test_win();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
